// File: rtl/ship_game_sequencer.sv
// ship_game_sequencer: frame-rate game sequencer that owns ship position, lives and game state.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   frame_tick   one-clk pulse per video frame
//   start_btn    debounced start button (rising edge starts a game)
//   left/right   movement requests, level
//   collision    ship/asteroid overlap, level
//   ship_x       ship centre x (registered)
//   ship_y       ship centre y, constant SHIP_Y
//   ship_visible renderer draws the ship when 1 (registered)
//   lives        remaining lives (registered)
//   state        0 ATTRACT, 1 PLAY, 2 EXPLODE, 3 OVER (registered)
//   game_over    high in OVER (registered)
//
// Build option: define SHIP_WRAP_EN to wrap the ship around the screen edges
// instead of clamping it.
module ship_game_sequencer #(
    parameter int X_START        = 320,
    parameter int SHIP_Y         = 240,
    parameter int X_MIN          = 12,
    parameter int X_MAX          = 627,
    parameter int STEP           = 2,
    parameter int LIVES          = 3,
    parameter int EXPLODE_FRAMES = 60,
    parameter int INVULN_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       left,
    input  logic       right,
    input  logic       collision,
    output logic [9:0] ship_x,
    output logic [9:0] ship_y,
    output logic       ship_visible,
    output logic [1:0] lives,
    output logic [1:0] state,
    output logic       game_over
);
    localparam int TW = $clog2(EXPLODE_FRAMES + 1);
    localparam int IW = $clog2(INVULN_FRAMES + 1);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] STEP11 = 11'(STEP);

    typedef enum logic [1:0] {ATTRACT, PLAY, EXPLODE, OVER} state_t;

    state_t        st, st_n;
    logic [9:0]    x, x_n;
    logic [1:0]    lv, lv_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [IW-1:0] inv, inv_n;
    logic          vis_n, start_q, start_rise;
    logic [10:0]   xw, x_left, x_right;

    assign start_rise = start_btn & ~start_q;
    // Edge comparisons are done in 11 bits so X_MIN-STEP / X_MAX+STEP cannot wrap.
    assign xw = {1'b0, x};
`ifdef SHIP_WRAP_EN
    assign x_left  = (xw < XMIN11 + STEP11) ? XMAX11 : xw - STEP11;
    assign x_right = (xw > XMAX11 - STEP11) ? XMIN11 : xw + STEP11;
`else
    assign x_left  = (xw < XMIN11 + STEP11) ? XMIN11 : xw - STEP11;
    assign x_right = (xw > XMAX11 - STEP11) ? XMAX11 : xw + STEP11;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= ATTRACT;
            x            <= 10'(X_START);
            lv           <= 2'(LIVES);
            tmr          <= '0;
            inv          <= '0;
            start_q      <= 1'b0;
            ship_visible <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            st           <= st_n;
            x            <= x_n;
            lv           <= lv_n;
            tmr          <= tmr_n;
            inv          <= inv_n;
            start_q      <= start_btn;
            ship_visible <= vis_n;
            game_over    <= (st_n == OVER);
        end
    end

    always_comb begin
        st_n  = st;
        x_n   = x;
        lv_n  = lv;
        tmr_n = tmr;
        inv_n = inv;
        if (st == ATTRACT || st == OVER) begin
            if (start_rise) begin
                st_n  = PLAY;
                lv_n  = 2'(LIVES);
                x_n   = 10'(X_START);
                inv_n = IW'(INVULN_FRAMES);
            end
        end else if (st == PLAY) begin
            // A hit takes priority over movement on a coincident frame tick.
            if (collision && inv == '0) begin
                st_n  = EXPLODE;
                lv_n  = lv - 2'd1;
                tmr_n = TW'(EXPLODE_FRAMES);
            end else if (frame_tick) begin
                inv_n = (inv != '0) ? inv - IW'(1) : inv;
                x_n   = (left && !right) ? 10'(x_left) : (right && !left) ? 10'(x_right) : x;
            end
        end else if (frame_tick) begin
            tmr_n = tmr - TW'(1);
            if (tmr == TW'(1)) begin
                st_n  = (lv == 2'd0) ? OVER : PLAY;
                x_n   = (lv == 2'd0) ? x : 10'(X_START);
                inv_n = (lv == 2'd0) ? inv : IW'(INVULN_FRAMES);
            end
        end
        // Blinks with bit 3 of the invulnerability count, i.e. every 8 frames.
        vis_n = (st_n == PLAY) && (inv_n == '0 || inv_n[3]);
    end

    assign ship_x = x;
    assign ship_y = 10'(SHIP_Y);
    assign lives  = lv;
    assign state  = st;
endmodule

// File: tb/tb_ship_game_sequencer.sv
// tb_ship_game_sequencer: directed and randomized checks of ship_game_sequencer against a behavioural model.
module tb_ship_game_sequencer;
    localparam int X_START = 320, SHIP_Y = 240, X_MIN = 12, X_MAX = 627, STEP = 2;
    localparam int LIVES = 3, EXPLODE_FRAMES = 60, INVULN_FRAMES = 120;

    logic       clk = 1'b0;
    logic       reset = 1'b1, frame_tick = 1'b0, start_btn = 1'b0;
    logic       left = 1'b0, right = 1'b0, collision = 1'b0;
    logic [9:0] ship_x, ship_y;
    logic       ship_visible, game_over;
    logic [1:0] lives, state;

    int checks = 0, errors = 0;

    // Behavioural model: game phase names and counters as plain integers.
    int m_phase, m_x, m_lives, m_timer, m_inv;
    bit m_start_prev;

    ship_game_sequencer dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .left(left), .right(right), .collision(collision), .ship_x(ship_x),
        .ship_y(ship_y), .ship_visible(ship_visible), .lives(lives),
        .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic begin_life();
        m_phase = 1;
        m_x     = X_START;
        m_inv   = INVULN_FRAMES;
    endtask

    task automatic model_step(input bit rs, ft, sb, l, r, c);
        bit rise;
        rise = sb && !m_start_prev;
        m_start_prev = sb;
        if (rs) begin
            m_phase = 0; m_x = X_START; m_lives = LIVES; m_timer = 0; m_inv = 0; m_start_prev = 0;
            return;
        end
        if (m_phase == 0 || m_phase == 3) begin
            if (rise) begin
                begin_life();
                m_lives = LIVES;
            end
        end else if (m_phase == 1) begin
            if (c && m_inv == 0) begin
                m_phase = 2;
                m_lives--;
                m_timer = EXPLODE_FRAMES;
            end else if (ft) begin
                if (m_inv > 0) m_inv--;
                if (l && !r) begin
`ifdef SHIP_WRAP_EN
                    m_x = (m_x - STEP < X_MIN) ? X_MAX : m_x - STEP;
`else
                    m_x = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
`endif
                end else if (r && !l) begin
`ifdef SHIP_WRAP_EN
                    m_x = (m_x + STEP > X_MAX) ? X_MIN : m_x + STEP;
`else
                    m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
`endif
                end
            end
        end else if (ft) begin
            m_timer--;
            if (m_timer == 0) begin
                if (m_lives == 0) m_phase = 3;
                else begin_life();
            end
        end
    endtask

    task automatic cyc(input bit rs, ft, sb, l, r, c);
        reset = rs; frame_tick = ft; start_btn = sb; left = l; right = r; collision = c;
        @(posedge clk);
        model_step(rs, ft, sb, l, r, c);
        #1;
        check("state", 32'(state), 32'(m_phase));
        check("ship_x", 32'(ship_x), 32'(m_x));
        check("lives", 32'(lives), 32'(m_lives));
        check("ship_visible", 32'(ship_visible),
              32'(m_phase == 1 && (m_inv == 0 || (m_inv / 8) % 2 == 1)));
        check("game_over", 32'(game_over), 32'(m_phase == 3));
    endtask

    task automatic ticks(input int n, input bit l, r);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, l, r, 0);
            cyc(0, 0, 0, l, r, 0);
        end
    endtask

    initial begin
        m_start_prev = 0;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        check("reset_state", 32'(state), 0);
        check("reset_x", 32'(ship_x), X_START);
        check("reset_lives", 32'(lives), LIVES);
        check("reset_vis", 32'(ship_visible), 0);
        check("reset_go", 32'(game_over), 0);
        check("ship_y", 32'(ship_y), SHIP_Y);

        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0);
        check("start_state", 32'(state), 1);
        check("start_lives", 32'(lives), 3);
        check("start_x", 32'(ship_x), 320);
        cyc(0, 0, 0, 0, 0, 0);
        ticks(INVULN_FRAMES, 0, 0);
        check("invuln_done_vis", 32'(ship_visible), 1);

        ticks(10, 0, 1);
        check("right10", 32'(ship_x), 340);
        ticks(5, 1, 1);
        check("both_hold", 32'(ship_x), 340);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 0);
        check("no_tick_hold", 32'(ship_x), 340);

        ticks(164, 1, 0);
        check("left_to_min", 32'(ship_x), 12);
        ticks(1, 1, 0);
`ifdef SHIP_WRAP_EN
        check("left_wrap", 32'(ship_x), 627);
        ticks(1, 0, 1);
        check("right_wrap", 32'(ship_x), 12);
`else
        check("left_clamp", 32'(ship_x), 12);
`endif

        cyc(0, 1, 0, 0, 0, 1);
        check("hit_state", 32'(state), 2);
        check("hit_lives", 32'(lives), 2);
        check("hit_vis", 32'(ship_visible), 0);
        ticks(5, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("explode_ignores", 32'(state), 2);
        ticks(EXPLODE_FRAMES - 5, 0, 0);
        check("respawn_state", 32'(state), 1);
        check("respawn_x", 32'(ship_x), 320);

        ticks(70, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("invuln_ignore", 32'(state), 1);
        ticks(50, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("hit2_lives", 32'(lives), 1);
        ticks(EXPLODE_FRAMES, 0, 0);
        ticks(INVULN_FRAMES, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        ticks(EXPLODE_FRAMES, 0, 0);
        check("over_state", 32'(state), 3);
        check("over_go", 32'(game_over), 1);
        check("over_lives", 32'(lives), 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("restart_state", 32'(state), 1);
        check("restart_lives", 32'(lives), 3);

        ticks(INVULN_FRAMES, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        ticks(7, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("midreset_state", 32'(state), 0);
        check("midreset_lives", 32'(lives), 3);
        check("midreset_x", 32'(ship_x), 320);
        check("midreset_go", 32'(game_over), 0);

        for (int i = 0; i < 6000; i++)
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 99) < 5, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
